issue_ctrl: RTL

//  Registered issue stage of the Tomasulo core. Pops one instruction per cycle from the

---
 rtl/issue_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Registered issue stage: pops the instruction queue, decodes, picks a reservation-station
// class and emits a one-cycle issue bundle. Define ISSUE_STATS_EN to add issue/stall counters.
module issue_ctrl #(
    parameter int NUM_RS = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst,
    input  logic [NUM_RS-1:0] rs_full,
    input  logic              flush,
    output logic              iss_valid,
    output logic [NUM_RS-1:0] iss_rs_en,
    output logic [1:0]        iss_aluop,
    output logic              iss_regdst,
    output logic              iss_vksrc,
    output logic              iss_queue_op,
    output logic [4:0]        iss_rs,
    output logic [4:0]        iss_rt,
    output logic [4:0]        iss_rd,
    output logic [15:0]       iss_imm,
    output logic              halted,
    output logic              illegal
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_issued,
    output logic [CNT_W-1:0]  stat_stalls
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALTED = 2'd2} state_t;

    state_t      state, state_next;
    logic [5:0]  op, func;
    logic [1:0]  dec_cls, dec_aluop;
    logic        dec_halt, dec_illegal, dec_rform, needs_class;
    logic [3:0]  full4;
    logic        target_full, ready, accept, do_issue;
    logic [NUM_RS-1:0] rs_onehot;
    logic        unused_full;

    assign op          = inst[31:26];
    assign func        = inst[5:0];
    assign dec_rform   = (op == 6'b000000);
    assign needs_class = !dec_halt && !dec_illegal;
    // Only the four real classes can stall issue; upper rs_full bits are don't-care.
    assign full4       = rs_full[3:0];
    assign target_full = full4[dec_cls];
    assign unused_full = ^rs_full;
    assign rs_onehot   = NUM_RS'(4'b0001 << dec_cls);

    always_comb begin
        dec_cls     = 2'd0;
        dec_aluop   = 2'b00;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: dec_aluop = 2'b00;
                    6'b100010: dec_aluop = 2'b01;
                    6'b100100: dec_aluop = 2'b10;
                    6'b100101: dec_aluop = 2'b11;
                    6'b011001: dec_cls   = 2'd1;
                    6'b011011: dec_cls   = 2'd2;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001000:            dec_aluop = 2'b00;
            6'b001101:            dec_aluop = 2'b11;
            6'b100011, 6'b101011: dec_cls   = 2'd3;
            6'b111111:            dec_halt  = 1'b1;
            default:              dec_illegal = 1'b1;
        endcase
    end

    // HALT and illegal encodings never wait on a class, so they are always takeable.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        if (flush) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN, STALL: begin
                    ready = !(needs_class && target_full);
                    if (inst_valid && ready)
                        state_next = dec_halt ? HALTED : RUN;
                    else if (inst_valid)
                        state_next = STALL;
                    else
                        state_next = RUN;
                end
                HALTED:  state_next = HALTED;
                default: state_next = RUN;
            endcase
        end
    end

    assign inst_ready = ready;
    assign accept     = inst_valid && ready;
    assign do_issue   = accept && needs_class;
    assign halted     = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            iss_valid    <= 1'b0;
            iss_rs_en    <= '0;
            illegal      <= 1'b0;
            iss_aluop    <= 2'b00;
            iss_regdst   <= 1'b0;
            iss_vksrc    <= 1'b0;
            iss_queue_op <= 1'b0;
            iss_rs       <= 5'd0;
            iss_rt       <= 5'd0;
            iss_rd       <= 5'd0;
            iss_imm      <= 16'd0;
        end else begin
            state     <= state_next;
            iss_valid <= do_issue;
            iss_rs_en <= do_issue ? rs_onehot : '0;
            illegal   <= accept && dec_illegal;
            // Payload fields hold their last value when nothing issues.
            if (do_issue) begin
                iss_aluop    <= dec_aluop;
                iss_regdst   <= dec_rform;
                iss_vksrc    <= !dec_rform;
                iss_queue_op <= (op != 6'b100011);
                iss_rs       <= inst[25:21];
                iss_rt       <= inst[20:16];
                iss_rd       <= inst[15:11];
                iss_imm      <= inst[15:0];
            end
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stalls <= '0;
        end else if (flush) begin
            stat_issued <= '0;
            stat_stalls <= '0;
        end else begin
            if (iss_valid && (stat_issued != '1))
                stat_issued <= stat_issued + 1'b1;
            if ((state == STALL) && (stat_stalls != '1))
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_stat;
    assign unused_stat = '0;
`endif

endmodule
